// File: rtl/spis_pkg.sv
// Shared definitions for the spis bus responder: bus widths, I/O page
// register addresses and TIMER_CTRL / STATUS bit positions.
package spis_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FETCH_W = 16;

    // Memory-mapped I/O page
    localparam logic [ADDR_W-1:0] ADDR_PORT_OUT     = 12'hF00;
    localparam logic [ADDR_W-1:0] ADDR_PORT_IN      = 12'hF01;
    localparam logic [ADDR_W-1:0] ADDR_TIMER_RELOAD = 12'hF02;
    localparam logic [ADDR_W-1:0] ADDR_TIMER_COUNT  = 12'hF03;
    localparam logic [ADDR_W-1:0] ADDR_TIMER_CTRL   = 12'hF04;
    localparam logic [ADDR_W-1:0] ADDR_STATUS       = 12'hF05;
    localparam logic [ADDR_W-1:0] ADDR_FETCH_LO     = 12'hF06;
    localparam logic [ADDR_W-1:0] ADDR_FETCH_HI     = 12'hF07;

    // TIMER_CTRL bits
    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FORCE  = 2;

    // STATUS bits
    localparam int unsigned STATUS_OVF = 0;

endpackage

// File: rtl/spis_timer.sv
// Prescaled 8-bit down-timer with sticky overflow flag.
// Ports:
//   clock, resetN        - clock, async active-low reset
//   enable               - run prescaler and count; 0 freezes both
//   reload_we/reload_data- TIMER_RELOAD store
//   force_reload         - count <= reload, prescaler <= 0 (beats a tick)
//   clear_ovf            - clear overflow (a simultaneous overflow wins)
//   reload, count        - register values for readback
//   overflow             - sticky overflow flag
module spis_timer
    import spis_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              enable,
    input  logic              reload_we,
    input  logic [DATA_W-1:0] reload_data,
    input  logic              force_reload,
    input  logic              clear_ovf,
    output logic [DATA_W-1:0] reload,
    output logic [DATA_W-1:0] count,
    output logic              overflow
);

    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler;
    logic            tick_c;
    logic            wrap_c;

    // A tick is the cycle the prescaler wraps; a wrap is a tick at count 0.
    assign tick_c = enable && (prescaler == PS_LAST);
    assign wrap_c = tick_c && (count == '0);

    // Timer state; reload uses the pre-edge value, so a same-cycle
    // TIMER_RELOAD store only affects later reloads.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            prescaler <= '0;
            count     <= '0;
            reload    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (reload_we) begin
                reload <= reload_data;
            end

            if (force_reload) begin
                prescaler <= '0;
                count     <= reload;
            end else if (enable) begin
                prescaler <= tick_c ? '0 : prescaler + 1'b1;
                if (tick_c) begin
                    count <= (count == '0) ? reload : count - 1'b1;
                end
            end

            if (wrap_c && !force_reload) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spis_bus_responder.sv
// Sole bus responder for the spis CPU: RAM at 0x000 plus an I/O page at
// 0xF00 (output port, synchronised input port, down-timer, fetch counter).
// Ports:
//   clock, resetN - clock, async active-low reset
//   dataBus       - bidirectional data; driven with read data while write = 0
//   addressBus    - CPU address
//   write         - store cycle, sampled on the rising edge
//   sync          - opcode-fetch strobe, counted by the fetch counter
//   portIn        - asynchronous external input port
//   portOut       - output port register
//   timerIrq      - timer overflow gated by irqEnable
module spis_bus_responder
    import spis_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 3840,
    parameter int unsigned PRESCALE  = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              resetN,
    inout  wire  [DATA_W-1:0] dataBus,
    input  logic [ADDR_W-1:0] addressBus,
    input  logic              write,
    input  logic              sync,
    input  logic [DATA_W-1:0] portIn,
    output logic [DATA_W-1:0] portOut,
    output logic              timerIrq
);

    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [DATA_W-1:0]  ram [RAM_DEPTH];
    logic [RAM_AW-1:0]  ram_idx_c;
    logic               in_ram_c;
    logic [DATA_W-1:0]  rd_data_c;

    logic [DATA_W-1:0]  port_in_meta;
    logic [DATA_W-1:0]  port_in_sync;
    logic               ctrl_enable;
    logic               ctrl_irq_en;
    logic [FETCH_W-1:0] fetch_count;

    logic               wr_port_out_c;
    logic               wr_reload_c;
    logic               wr_ctrl_c;
    logic               wr_status_c;
    logic               wr_fetch_c;

    logic [DATA_W-1:0]  timer_reload;
    logic [DATA_W-1:0]  timer_count;
    logic               timer_ovf;

    assign in_ram_c  = 32'(addressBus) < RAM_DEPTH;
    assign ram_idx_c = RAM_AW'(addressBus);

    // RAM store; contents survive reset
    always_ff @(posedge clock) begin
        if (write && in_ram_c) begin
            ram[ram_idx_c] <= dataBus;
        end
    end

    // Store decode for the I/O page
    always_comb begin
        wr_port_out_c = write && (addressBus == ADDR_PORT_OUT);
        wr_reload_c   = write && (addressBus == ADDR_TIMER_RELOAD);
        wr_ctrl_c     = write && (addressBus == ADDR_TIMER_CTRL);
        wr_status_c   = write && (addressBus == ADDR_STATUS);
        wr_fetch_c    = write && ((addressBus == ADDR_FETCH_LO) ||
                                  (addressBus == ADDR_FETCH_HI));
    end

    // I/O registers, input synchroniser and fetch counter
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            portOut      <= '0;
            port_in_meta <= '0;
            port_in_sync <= '0;
            ctrl_enable  <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            fetch_count  <= '0;
        end else begin
            port_in_meta <= portIn;
            port_in_sync <= port_in_meta;
            if (wr_port_out_c) begin
                portOut <= dataBus;
            end
            if (wr_ctrl_c) begin
                ctrl_enable <= dataBus[CTRL_ENABLE];
                ctrl_irq_en <= dataBus[CTRL_IRQ_EN];
            end
            // Clear beats a simultaneous sync
            if (wr_fetch_c) begin
                fetch_count <= '0;
            end else if (sync) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

    spis_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clock        (clock),
        .resetN       (resetN),
        .enable       (ctrl_enable),
        .reload_we    (wr_reload_c),
        .reload_data  (dataBus),
        .force_reload (wr_ctrl_c && dataBus[CTRL_FORCE]),
        .clear_ovf    (wr_status_c && dataBus[STATUS_OVF]),
        .reload       (timer_reload),
        .count        (timer_count),
        .overflow     (timer_ovf)
    );

    assign timerIrq = timer_ovf && ctrl_irq_en;

    // Zero-latency read mux; unmapped locations read 0
    always_comb begin
        rd_data_c = '0;
        if (in_ram_c) begin
            rd_data_c = ram[ram_idx_c];
        end else begin
            case (addressBus)
                ADDR_PORT_OUT:     rd_data_c = portOut;
                ADDR_PORT_IN:      rd_data_c = port_in_sync;
                ADDR_TIMER_RELOAD: rd_data_c = timer_reload;
                ADDR_TIMER_COUNT:  rd_data_c = timer_count;
                ADDR_TIMER_CTRL: begin
                    rd_data_c[CTRL_ENABLE] = ctrl_enable;
                    rd_data_c[CTRL_IRQ_EN] = ctrl_irq_en;
                end
                ADDR_STATUS:       rd_data_c[STATUS_OVF] = timer_ovf;
                ADDR_FETCH_LO:     rd_data_c = fetch_count[DATA_W-1:0];
                ADDR_FETCH_HI:     rd_data_c = fetch_count[FETCH_W-1:DATA_W];
                default:           rd_data_c = '0;
            endcase
        end
    end

    // Bus released only during stores; reset keeps it driven
    assign dataBus = write ? {DATA_W{1'bz}} : rd_data_c;

endmodule

// File: tb/tb_spis_bus_responder.sv
// Scoreboard bench for spis_bus_responder against a behavioural model.
module tb_spis_bus_responder;

    localparam int unsigned PRESCALE  = 4;
    localparam int unsigned RAM_DEPTH = 3840;

    logic        clock = 1'b0;
    logic        resetN;
    wire  [7:0]  dataBus;
    logic [11:0] addressBus;
    logic        write;
    logic        sync;
    logic [7:0]  portIn;
    logic [7:0]  portOut;
    logic        timerIrq;

    logic        drv_en;
    logic [7:0]  drv_data;
    logic        rd_valid;

    assign dataBus = drv_en ? drv_data : 8'hzz;

    always #5 clock = ~clock;

    spis_bus_responder #(
        .RAM_DEPTH (RAM_DEPTH),
        .PRESCALE  (PRESCALE),
        .INIT_FILE ("")
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .dataBus    (dataBus),
        .addressBus (addressBus),
        .write      (write),
        .sync       (sync),
        .portIn     (portIn),
        .portOut    (portOut),
        .timerIrq   (timerIrq)
    );

    // Scoreboard: kind 0 = dataBus, 1 = portOut, 2 = timerIrq
    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [7:0]  exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model state
    logic [7:0] m_mem [4096];
    bit         m_wr  [4096];
    logic [7:0] m_port;
    int         m_reload;
    int         m_c0;       // count loaded by the last force/reset
    int         m_el;       // enabled edges since that load
    bit         m_en, m_irqen, m_ovf;
    int         m_fetch;
    logic [7:0] m_p1, m_p2;

    function automatic string kname(input int k);
        if (k == 0) return "bus_read";
        if (k == 1) return "portOut";
        return "timerIrq";
    endfunction

    // Overflow events after t ticks: count runs c0..0, then period reload+1
    function automatic int n_ovf(input int t);
        if (t <= m_c0) return 0;
        return 1 + (t - m_c0 - 1) / (m_reload + 1);
    endfunction

    function automatic logic [7:0] m_count();
        int t;
        t = m_el / int'(PRESCALE);
        if (t <= m_c0) return 8'(m_c0 - t);
        return 8'(m_reload - ((t - m_c0 - 1) % (m_reload + 1)));
    endfunction

    function automatic logic [7:0] model_read(input logic [11:0] a);
        if (32'(a) < RAM_DEPTH) return m_mem[a];
        case (a)
            12'hF00: return m_port;
            12'hF01: return m_p2;
            12'hF02: return 8'(m_reload);
            12'hF03: return m_count();
            12'hF04: return {6'b0, m_irqen, m_en};
            12'hF05: return {7'b0, m_ovf};
            12'hF06: return 8'(m_fetch);
            12'hF07: return 8'(m_fetch >> 8);
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        m_port = 8'h00; m_reload = 0; m_c0 = 0; m_el = 0;
        m_en = 0; m_irqen = 0; m_ovf = 0; m_fetch = 0;
        m_p1 = 8'h00; m_p2 = 8'h00;
    endfunction

    // Effect of one rising edge
    function automatic void model_edge(input bit w, input logic [11:0] a,
                                       input logic [7:0] d, input bit s);
        int t0, t1;
        if (!resetN) return;
        t0 = m_el / int'(PRESCALE);
        if (w && a == 12'hF04 && d[2]) begin
            m_el = 0;
            m_c0 = m_reload;
        end else begin
            if (m_en) m_el++;
            t1 = m_el / int'(PRESCALE);
            if (w && a == 12'hF05 && d[0]) m_ovf = 0;
            if (n_ovf(t1) > n_ovf(t0)) m_ovf = 1;
        end
        if (w) begin
            if (32'(a) < RAM_DEPTH) begin
                m_mem[a] = d;
                m_wr[a]  = 1;
            end
            case (a)
                12'hF00: m_port = d;
                12'hF02: m_reload = int'(d);
                12'hF04: begin m_en = d[0]; m_irqen = d[1]; end
                default: ;
            endcase
        end
        if (w && (a == 12'hF06 || a == 12'hF07)) m_fetch = 0;
        else if (s) m_fetch = (m_fetch + 1) % 65536;
        m_p2 = m_p1;
        m_p1 = portIn;
    endfunction

    // One bus cycle, entered and left at posedge+1
    task automatic do_cycle(input bit w, input logic [11:0] a, input logic [7:0] d,
                            input bit s, input int kind, input logic [7:0] exp_v);
        addressBus = a;
        write      = w;
        sync       = s;
        drv_en     = w;
        drv_data   = d;
        if (kind >= 0) begin
            exp_q.push_back('{kind: kind, addr: a, exp: exp_v});
            rd_valid = 1'b1;
        end else begin
            rd_valid = 1'b0;
        end
        model_edge(w, a, d, s);
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        do_cycle(1'b1, a, d, 1'b0, -1, 8'h00);
    endtask

    task automatic rd(input logic [11:0] a);
        do_cycle(1'b0, a, 8'h00, 1'b0, 0, model_read(a));
    endtask

    task automatic rdx(input logic [11:0] a, input logic [7:0] e);
        do_cycle(1'b0, a, 8'h00, 1'b0, 0, e);
    endtask

    task automatic idle(input bit s);
        do_cycle(1'b0, 12'hF80, 8'h00, s, -1, 8'h00);
    endtask

    task automatic chk_out(input int kind, input logic [7:0] e);
        do_cycle(1'b0, 12'hF80, 8'h00, 1'b0, kind, e);
    endtask

    // Monitor: compare whenever a checked cycle is on the bus
    always @(negedge clock) begin : monitor
        chk_t       c;
        logic [7:0] act;
        if (rd_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                c = exp_q.pop_front();
                case (c.kind)
                    0:       act = dataBus;
                    1:       act = portOut;
                    default: act = {7'b0, timerIrq};
                endcase
                if (act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s addr=%h actual=%h expected=%h at %0t",
                             kname(c.kind), c.addr, act, c.exp, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [11:0] a;
        logic [7:0]  d;
        logic [7:0]  p;
        bit          s;
        int          sel;

        addressBus = 12'h000; write = 1'b0; sync = 1'b0; portIn = 8'h00;
        drv_en = 1'b0; drv_data = 8'h00; rd_valid = 1'b0; resetN = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            m_mem[i] = 8'h00;
            m_wr[i]  = 0;
        end
        model_reset();
        @(posedge clock);
        #1;

        // Reset state
        rdx(12'hF00, 8'h00);
        chk_out(1, 8'h00);
        chk_out(2, 8'h00);
        rdx(12'hF03, 8'h00);
        rdx(12'hF06, 8'h00);
        resetN = 1'b1;

        p = 8'($urandom_range(1, 255));
        if (p == 8'h81) p = 8'h82;
        portIn = p;
        idle(1'b0); idle(1'b0); idle(1'b0);

        // Randomised traffic with the timer held disabled
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a = 12'h100 + 12'($urandom_range(0, 15));
                1:       a = 12'($urandom_range(0, 12'hEFF));
                2:       a = 12'hF00 + 12'($urandom_range(0, 15));
                default: a = 12'($urandom_range(0, 4095));
            endcase
            d = 8'($urandom);
            if (a == 12'hF04) d[0] = 1'b0;
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                do_cycle(1'b1, a, d, s, -1, 8'h00);
            else if (32'(a) < RAM_DEPTH && !m_wr[a])
                do_cycle(1'b0, a, 8'h00, s, -1, 8'h00);
            else if ($urandom_range(0, 7) == 0)
                do_cycle(1'b0, a, 8'h00, s, 1, m_port);
            else if ($urandom_range(0, 7) == 0)
                do_cycle(1'b0, a, 8'h00, s, 2, {7'b0, m_ovf & m_irqen});
            else
                do_cycle(1'b0, a, 8'h00, s, 0, model_read(a));
        end

        // Store / load and unmapped read
        wr(12'h123, 8'h5A);
        rdx(12'h123, 8'h5A);
        rdx(12'hF80, 8'h00);

        // Ports and input synchroniser latency
        wr(12'hF00, 8'hC3);
        chk_out(1, 8'hC3);
        portIn = 8'h81;
        rdx(12'hF01, p);
        rdx(12'hF01, p);
        rdx(12'hF01, 8'h81);
        // Responder must release the bus during a store
        do_cycle(1'b1, 12'hF01, 8'h00, 1'b0, 0, 8'h00);

        // Timer: reload 2, enable + irq + force
        wr(12'hF02, 8'h02);
        wr(12'hF04, 8'h07);
        for (int k = 0; k < 13; k++) rdx(12'hF03, 8'(2 - ((k / 4) % 3)));
        rdx(12'hF05, 8'h01);
        chk_out(2, 8'h01);
        wr(12'hF05, 8'h01);
        chk_out(2, 8'h00);

        // Force-reload on a wrapping tick: force wins, no overflow
        wr(12'hF02, 8'h00);
        wr(12'hF04, 8'h07);
        wr(12'hF05, 8'h01);
        while (m_el % int'(PRESCALE) != int'(PRESCALE) - 1) idle(1'b0);
        wr(12'hF04, 8'h07);
        rdx(12'hF05, 8'h00);
        rd(12'hF03);

        // STATUS clear on an overflow tick: set wins
        while (m_el % int'(PRESCALE) != int'(PRESCALE) - 1) idle(1'b0);
        wr(12'hF05, 8'h01);
        rdx(12'hF05, 8'h01);
        wr(12'hF04, 8'h00);
        rd(12'hF04);

        // Fetch counter
        wr(12'hF06, 8'hAA);
        for (int k = 0; k < 300; k++) idle(1'b1);
        rdx(12'hF07, 8'h01);
        rdx(12'hF06, 8'h2C);
        for (int k = 0; k < 65235; k++) idle(1'b1);
        rdx(12'hF06, 8'hFF);
        rdx(12'hF07, 8'hFF);
        idle(1'b1);
        rdx(12'hF06, 8'h00);
        rdx(12'hF07, 8'h00);
        idle(1'b1); idle(1'b1); idle(1'b1);
        rd(12'hF06);
        do_cycle(1'b1, 12'hF06, 8'h55, 1'b1, -1, 8'h00);
        rdx(12'hF06, 8'h00);
        rdx(12'hF07, 8'h00);

        // Set up a running timer with pending irq, then reset mid-count
        wr(12'hF00, 8'h3C);
        wr(12'hF02, 8'h05);
        wr(12'hF04, 8'h07);
        for (int k = 0; k < 30; k++) idle(1'b1);
        chk_out(2, 8'h01);
        rd(12'hF03);
        resetN = 1'b0;
        model_reset();
        rdx(12'hF00, 8'h00);
        chk_out(1, 8'h00);
        chk_out(2, 8'h00);
        rdx(12'hF03, 8'h00);
        rdx(12'hF05, 8'h00);
        rdx(12'hF06, 8'h00);
        rdx(12'hF01, 8'h00);
        rdx(12'hF04, 8'h00);
        rdx(12'hF02, 8'h00);
        rdx(12'h123, 8'h5A);
        resetN = 1'b1;
        rdx(12'hF01, 8'h00);
        idle(1'b0);
        rdx(12'hF01, 8'h81);

        rd_valid = 1'b0;
        idle(1'b0);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
